fft_stage_sched: RTL and testbench
==================================

Name: fft_stage_sched

Overview:
Sequencer for the in-place radix-2 DIT FFT datapath with ping-pong memory banks. Input samples are already in bit-reversed order in bank 0. Per stage, the block issues one butterfly read pair per cycle and generates the twiddle index. It delays the matching write addresses to line up with the butterfly output, then swaps banks. It sits between the bit-reverse loader and the butterfly/RAM datapath, and signals when the transform is complete.

Parameters:
N, 8, transform length; power of two, N>=4
LOG2N, 3, log2(N); address width and stage count
BF_LAT, 2, butterfly pipeline latency in cycles (>=0)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a transform when idle
busy  output  1  high from the cycle after start is accepted through the DONE cycle
done  output  1  one-cycle pulse when the last stage has been swapped
stage  output  LOG2N  current stage index, 0..LOG2N-1
rd_en  output  1  read strobe for both butterfly operands
rd_bank  output  1  bank being read; writes go to ~rd_bank
rd_addr_a  output  LOG2N  upper-leg read address
rd_addr_b  output  LOG2N  lower-leg read address
tw_addr  output  LOG2N-1  twiddle ROM index, valid with rd_en
wr_en  output  1  write strobe for both butterfly results
wr_addr_a  output  LOG2N  upper-leg write address
wr_addr_b  output  LOG2N  lower-leg write address
result_bank  output  1  bank holding the final spectrum; valid from done onward

Behaviour:
- Reset values: busy=0, done=0, stage=0, rd_en=0, rd_bank=0, all addresses=0, tw_addr=0, wr_en=0, result_bank=0. FSM goes to IDLE and the write pipeline is cleared.
- WR_DLY = BF_LAT+1. The extra cycle covers the synchronous RAM read.
- FSM states and transitions:
  - IDLE: start=1 -> ISSUE. On that edge: stage=0, rd_bank=0, butterfly counter bf=0.
  - ISSUE: rd_en=1 every cycle and bf increments. After bf=N/2-1 has been issued -> DRAIN.
  - DRAIN: exactly WR_DLY cycles with rd_en=0. The last write of the stage occurs in the final DRAIN cycle. Then -> SWAP.
  - SWAP: 1 cycle with rd_en=0 and wr_en=0. On exit rd_bank toggles. If stage=LOG2N-1 -> DONE; else stage increments, bf=0, -> ISSUE.
  - DONE: done=1 for one cycle, result_bank=rd_bank (already toggled), busy=1. Then -> IDLE with busy=0.
- Address generation, for span=1<<stage and pos=bf&(span-1):
  - rd_addr_a = ((bf>>stage)<<(stage+1)) | pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos<<(LOG2N-1-stage), truncated to LOG2N-1 bits
- Read outputs are registered: rd_en/addresses/tw_addr change on the edge entering the issue cycle.
- Write pipeline: {valid, a, b} is shifted WR_DLY stages. wr_en/wr_addr_a/wr_addr_b equal the read values from exactly WR_DLY cycles earlier.
- Cycles per stage = N/2 + WR_DLY + 1. Start accepted at edge 0 -> done high in cycle LOG2N*(N/2+WR_DLY+1)+1. For defaults that is cycle 25.
- start while busy: ignored.
- start in the same cycle as DONE: ignored; a new start must come from IDLE.
- rst mid-operation: immediate return to IDLE. No further wr_en, including any writes still in flight in the pipeline.
- result_bank holds its value until the next start is accepted. It is not cleared by start, only by rst.

Optional Feature:
Macro FFT_SCHED_HOLD_EN.
- When defined, add input port hold (1 bit). While hold=1 in ISSUE: rd_en=0, bf is frozen, and the read address outputs hold their values.
- The write pipeline keeps shifting during hold, so holds appear as wr_en=0 bubbles. Write timing relative to each issued read stays WR_DLY.
- hold is ignored in IDLE, DRAIN, SWAP and DONE. DRAIN still starts after the last real issue.
- When not defined: there is no hold port and ISSUE never stalls.

Test Plan:
1. Defaults; rst, then start pulse -> stage0 reads (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0 in cycles 1-4; wr_en at cycles 4-7 with the same pairs; rd_bank=0.
2. Continue run -> stage1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2 and rd_bank=1. Stage2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3 and rd_bank=0. Then done=1 at cycle 25, result_bank=1, busy=0 at cycle 26.
3. start pulses at cycles 3 and 25 during a run -> ignored. Exactly one done, at cycle 25.
4. rst asserted in cycle 10 (stage1 ISSUE) -> all outputs 0 immediately, no wr_en afterwards. A new start then reproduces scenario 1 timing exactly.
5. N=16, LOG2N=4, BF_LAT=0 -> WR_DLY=1, 10 cycles/stage, done at cycle 41. Stage3 tw sequence 0..7 and result_bank=0.
6. FFT_SCHED_HOLD_EN defined; hold=1 during cycles 2-3 of stage0 -> reads (0,1) in cycle 1, then (2,3),(4,5),(6,7) in cycles 4-6; wr_en in cycles 4,7,8,9; done at cycle 27.

Source files
------------

// File: rtl/fft_stage_sched_if.sv
// Control/status bundle between the FFT stage sequencer and its neighbours.
// The hold input exists only when FFT_SCHED_HOLD_EN is defined.
interface fft_stage_sched_if #(
  parameter int LOG2N = 3
);
  logic             start;
`ifdef FFT_SCHED_HOLD_EN
  logic             hold;
`endif
  logic             busy;
  logic             done;
  logic [LOG2N-1:0] stage;
  logic             rd_en;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             result_bank;

`ifdef FFT_SCHED_HOLD_EN
  modport master (
    output start, hold,
    input  busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, result_bank
  );
  modport slave (
    input  start, hold,
    output busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, result_bank
  );
`else
  modport master (
    output start,
    input  busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, result_bank
  );
  modport slave (
    input  start,
    output busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, result_bank
  );
`endif
endinterface

// File: rtl/fft_stage_sched.sv
// Radix-2 DIT in-place FFT stage sequencer with ping-pong banks and delayed write addresses.
// Optional issue stall input enabled by defining FFT_SCHED_HOLD_EN.
module fft_stage_sched #(
  parameter int N      = 8,
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  fft_stage_sched_if.slave  sched
);

  localparam int WR_DLY = BF_LAT + 1;
  localparam int BF_W   = LOG2N - 1;
  localparam int CNT_W  = (WR_DLY > 1) ? $clog2(WR_DLY) : 1;

  localparam logic [BF_W-1:0]  BF_LAST   = BF_W'(N / 2 - 1);
  localparam logic [LOG2N-1:0] TOP_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WR_DLY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_SWAP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             v;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wr_slot_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [BF_W-1:0]  r_bf;
  logic [LOG2N-1:0] r_stage;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bank;

  logic             w_hold;
  logic             w_issue;
  logic [LOG2N-1:0] w_bf_ext;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_addr_a;
  logic [LOG2N-1:0] w_addr_b;
  logic [BF_W-1:0]  w_tw;

  logic             r_busy;
  logic             r_done;
  logic [LOG2N-1:0] r_stage_q;
  logic             r_rd_en;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_rd_addr_a;
  logic [LOG2N-1:0] r_rd_addr_b;
  logic [BF_W-1:0]  r_tw_addr;
  logic             r_result_bank;

  wr_slot_t         r_pipe [WR_DLY];

`ifdef FFT_SCHED_HOLD_EN
  assign w_hold = sched.hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_issue = (r_state == S_ISSUE) && !w_hold;

  // Butterfly bf of a stage: group = bf >> stage, position inside group = bf & (span-1).
  assign w_bf_ext = {1'b0, r_bf};
  assign w_span   = LOG2N'(1) << r_stage;
  assign w_pos    = w_bf_ext & (w_span - 1'b1);
  assign w_addr_a = ((w_bf_ext >> r_stage) << (r_stage + 1'b1)) | w_pos;
  assign w_addr_b = w_addr_a + w_span;
  assign w_tw     = w_pos[BF_W-1:0] << (TOP_STAGE - r_stage);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (sched.start) w_state_next = S_ISSUE;
      S_ISSUE: if (w_issue && (r_bf == BF_LAST)) w_state_next = S_DRAIN;
      S_DRAIN: if (r_cnt == CNT_LAST) w_state_next = S_SWAP;
      S_SWAP:  w_state_next = (r_stage == TOP_STAGE) ? S_DONE : S_ISSUE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bf    <= '0;
      r_stage <= '0;
      r_cnt   <= '0;
      r_bank  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (sched.start) begin
            r_bf    <= '0;
            r_stage <= '0;
            r_cnt   <= '0;
            r_bank  <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (w_issue) r_bf <= r_bf + 1'b1;
        end
        S_DRAIN: r_cnt <= r_cnt + 1'b1;
        S_SWAP: begin
          r_bank <= ~r_bank;
          r_bf   <= '0;
          r_cnt  <= '0;
          if (r_stage != TOP_STAGE) r_stage <= r_stage + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Externally visible controls are registered and trail the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stage_q     <= '0;
      r_rd_en       <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_rd_addr_a   <= '0;
      r_rd_addr_b   <= '0;
      r_tw_addr     <= '0;
      r_result_bank <= 1'b0;
    end else begin
      r_busy    <= (r_state != S_IDLE);
      r_done    <= (r_state == S_DONE);
      r_stage_q <= r_stage;
      r_rd_en   <= w_issue;
      r_rd_bank <= r_bank;
      if (w_issue) begin
        r_rd_addr_a <= w_addr_a;
        r_rd_addr_b <= w_addr_b;
        r_tw_addr   <= w_tw;
      end
      if (r_state == S_DONE) r_result_bank <= r_bank;
    end
  end

  // NOTE: the delay line is reset so in-flight write strobes die with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WR_DLY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{v: r_rd_en, a: r_rd_addr_a, b: r_rd_addr_b};
      for (int i = 1; i < WR_DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign sched.busy        = r_busy;
  assign sched.done        = r_done;
  assign sched.stage       = r_stage_q;
  assign sched.rd_en       = r_rd_en;
  assign sched.rd_bank     = r_rd_bank;
  assign sched.rd_addr_a   = r_rd_addr_a;
  assign sched.rd_addr_b   = r_rd_addr_b;
  assign sched.tw_addr     = r_tw_addr;
  assign sched.wr_en       = r_pipe[WR_DLY-1].v;
  assign sched.wr_addr_a   = r_pipe[WR_DLY-1].a;
  assign sched.wr_addr_b   = r_pipe[WR_DLY-1].b;
  assign sched.result_bank = r_result_bank;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Bench for fft_stage_sched: N=8/BF_LAT=2 and N=16/BF_LAT=0 instances run side by side
// against a per-cycle schedule built from the butterfly group/position loops.
module tb_fft_stage_sched;

  localparam int MAXC = 160;

`ifdef FFT_SCHED_HOLD_EN
  localparam int EXP_DONE8_R1  = 27;
  localparam int EXP_DONE16_R1 = 43;
`else
  localparam int EXP_DONE8_R1  = 25;
  localparam int EXP_DONE16_R1 = 41;
`endif

  logic clk = 1'b0;
  logic rst;
  logic hold_drv;

  always #5 clk = ~clk;

  fft_stage_sched_if #(.LOG2N(3)) bus8 ();
  fft_stage_sched_if #(.LOG2N(4)) bus16 ();

`ifdef FFT_SCHED_HOLD_EN
  assign bus8.hold  = hold_drv;
  assign bus16.hold = hold_drv;
`endif

  fft_stage_sched #(.N(8), .LOG2N(3), .BF_LAT(2)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .sched (bus8)
  );

  fft_stage_sched #(.N(16), .LOG2N(4), .BF_LAT(0)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .sched (bus16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int e_rd    [2][MAXC];
  int e_a     [2][MAXC];
  int e_b     [2][MAXC];
  int e_tw    [2][MAXC];
  int e_bank  [2][MAXC];
  int e_stage [2][MAXC];
  int e_wr    [2][MAXC];
  int e_wa    [2][MAXC];
  int e_wb    [2][MAXC];
  int done_c  [2];
  int e_rb    [2];
  int hold_at [MAXC];
  int spur    [2][MAXC];
  int obs     [12];

  string onames [12] = '{"busy", "done", "stage", "rd_en", "rd_bank", "rd_addr_a",
                         "rd_addr_b", "tw_addr", "wr_en", "wr_addr_a", "wr_addr_b",
                         "result_bank"};

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  // Expected schedule: reads issue one per cycle from cycle 1, skipping held edges;
  // each stage costs WR_DLY drain cycles plus one swap cycle after its last read.
  task automatic build_model(input int d, input int n, input int lg, input int wd);
    int t;
    int span;
    int a;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[d][c] = 0; e_a[d][c] = 0; e_b[d][c] = 0; e_tw[d][c] = 0;
      e_bank[d][c] = 0; e_stage[d][c] = 0;
      e_wr[d][c] = 0; e_wa[d][c] = 0; e_wb[d][c] = 0;
    end
    t = 1;
    for (int s = 0; s < lg; s++) begin
      span = 1 << s;
      for (int g = 0; g < n / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          while (hold_at[t] != 0) t++;
          a = g * 2 * span + p;
          e_rd[d][t]    = 1;
          e_a[d][t]     = a;
          e_b[d][t]     = a + span;
          e_tw[d][t]    = p * (n / (2 * span));
          e_bank[d][t]  = s % 2;
          e_stage[d][t] = s;
          e_wr[d][t+wd] = 1;
          e_wa[d][t+wd] = a;
          e_wb[d][t+wd] = a + span;
          t++;
        end
      end
      t = t + wd + 1;
    end
    done_c[d] = t;
    e_rb[d]   = lg % 2;
  endtask

  task automatic grab(input int d);
    if (d == 0) begin
      obs[0] = int'(bus8.busy);      obs[1]  = int'(bus8.done);
      obs[2] = int'(bus8.stage);     obs[3]  = int'(bus8.rd_en);
      obs[4] = int'(bus8.rd_bank);   obs[5]  = int'(bus8.rd_addr_a);
      obs[6] = int'(bus8.rd_addr_b); obs[7]  = int'(bus8.tw_addr);
      obs[8] = int'(bus8.wr_en);     obs[9]  = int'(bus8.wr_addr_a);
      obs[10] = int'(bus8.wr_addr_b); obs[11] = int'(bus8.result_bank);
    end else begin
      obs[0] = int'(bus16.busy);      obs[1]  = int'(bus16.done);
      obs[2] = int'(bus16.stage);     obs[3]  = int'(bus16.rd_en);
      obs[4] = int'(bus16.rd_bank);   obs[5]  = int'(bus16.rd_addr_a);
      obs[6] = int'(bus16.rd_addr_b); obs[7]  = int'(bus16.tw_addr);
      obs[8] = int'(bus16.wr_en);     obs[9]  = int'(bus16.wr_addr_a);
      obs[10] = int'(bus16.wr_addr_b); obs[11] = int'(bus16.result_bank);
    end
  endtask

  task automatic check_all_zero(input string when);
    for (int d = 0; d < 2; d++) begin
      grab(d);
      for (int i = 0; i < 12; i++)
        check($sformatf("%s.n%0d.%s", when, (d == 0) ? 8 : 16, onames[i]), obs[i], 0);
    end
  endtask

  task automatic cmp(input int d, input int t);
    string p;
    p = $sformatf("n%0d.c%0d", (d == 0) ? 8 : 16, t);
    grab(d);
    check({p, ".rd_en"}, obs[3], e_rd[d][t]);
    if (e_rd[d][t] != 0) begin
      check({p, ".rd_addr_a"}, obs[5], e_a[d][t]);
      check({p, ".rd_addr_b"}, obs[6], e_b[d][t]);
      check({p, ".tw_addr"},   obs[7], e_tw[d][t]);
      check({p, ".rd_bank"},   obs[4], e_bank[d][t]);
      check({p, ".stage"},     obs[2], e_stage[d][t]);
    end
    check({p, ".wr_en"}, obs[8], e_wr[d][t]);
    if (e_wr[d][t] != 0) begin
      check({p, ".wr_addr_a"}, obs[9],  e_wa[d][t]);
      check({p, ".wr_addr_b"}, obs[10], e_wb[d][t]);
    end
    check({p, ".done"}, obs[1], (t == done_c[d]) ? 1 : 0);
    check({p, ".busy"}, obs[0], (t >= 1 && t <= done_c[d]) ? 1 : 0);
    if (t >= done_c[d]) check({p, ".result_bank"}, obs[11], e_rb[d]);
  endtask

  task automatic set_holds(input int mode);
    for (int c = 0; c < MAXC; c++) hold_at[c] = 0;
`ifdef FFT_SCHED_HOLD_EN
    if (mode == 1) begin
      hold_at[2] = 1;
      hold_at[3] = 1;
    end else if (mode == 2) begin
      for (int c = 1; c < 40; c++) hold_at[c] = ($urandom_range(3, 0) == 0) ? 1 : 0;
    end
`else
    if (mode > 2) $display("set_holds: unknown mode %0d", mode);
`endif
  endtask

  // Starts both instances at edge 0 (called just after a falling edge, both idle) and
  // compares every cycle; extra start pulses land only while each instance is busy.
  task automatic run_pair(output int dc8, output int dc16);
    int lim;
    int seen [2];
    int dc   [2];
    build_model(0, 8, 3, 3);
    build_model(1, 16, 4, 1);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < MAXC; c++) spur[d][c] = 0;
      spur[d][3]         = 1;
      spur[d][done_c[d]] = 1;
      repeat (2) spur[d][int'($urandom_range(done_c[d], 1))] = 1;
      seen[d] = 0;
      dc[d]   = -1;
    end
    lim = ((done_c[0] > done_c[1]) ? done_c[0] : done_c[1]) + 3;
    bus8.start  = 1'b1;
    bus16.start = 1'b1;
    hold_drv    = (hold_at[0] != 0);
    for (int t = 0; t <= lim; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t >= 1) begin
        for (int d = 0; d < 2; d++) begin
          cmp(d, t);
          if (obs[1] != 0) begin
            seen[d]++;
            dc[d] = t;
          end
        end
      end
      bus8.start  = (spur[0][t+1] != 0);
      bus16.start = (spur[1][t+1] != 0);
      hold_drv    = (hold_at[t+1] != 0);
    end
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    hold_drv    = 1'b0;
    check("n8.done_count",  seen[0], 1);
    check("n16.done_count", seen[1], 1);
    dc8  = dc[0];
    dc16 = dc[1];
  endtask

  initial begin
    int dc8;
    int dc16;
    rst         = 1'b1;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    hold_drv    = 1'b0;
    set_holds(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    set_holds(1);
    run_pair(dc8, dc16);
    check("n8.done_cycle_run1",  dc8,  EXP_DONE8_R1);
    check("n16.done_cycle_run1", dc16, EXP_DONE16_R1);

    set_holds(0);
    run_pair(dc8, dc16);
    check("n8.done_cycle_nohold",  dc8,  25);
    check("n16.done_cycle_nohold", dc16, 41);

    repeat (3) begin
      set_holds(2);
      run_pair(dc8, dc16);
    end

    // Abort both instances mid-stage with rst, then confirm a clean restart.
    set_holds(0);
    bus8.start  = 1'b1;
    bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        grab(d);
        check($sformatf("postrst.n%0d.c%0d.wr_en", (d == 0) ? 8 : 16, c), obs[8], 0);
        check($sformatf("postrst.n%0d.c%0d.rd_en", (d == 0) ? 8 : 16, c), obs[3], 0);
        check($sformatf("postrst.n%0d.c%0d.busy",  (d == 0) ? 8 : 16, c), obs[0], 0);
      end
    end
    run_pair(dc8, dc16);
    check("n8.done_cycle_restart",  dc8,  25);
    check("n16.done_cycle_restart", dc16, 41);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
